// File: rtl/id_ie_pipe_reg.sv
// ID/IE pipeline boundary register: carries decoded operands and control into IE,
// inserts one bubble per load-use hazard, squashes on flush, freezes on MEM stall.
module id_ie_pipe_reg #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             id_alu_src,
   input  logic [3:0]       id_alu_op,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             id_reg_write,
   input  logic             flush,
   input  logic             stall_ext,
   output logic             ie_valid,
   output logic [XLEN-1:0]  ie_pc,
   output logic [XLEN-1:0]  ie_rs1_data,
   output logic [XLEN-1:0]  ie_rs2_data,
   output logic [XLEN-1:0]  ie_imm,
   output logic [RA_W-1:0]  ie_rs1,
   output logic [RA_W-1:0]  ie_rs2,
   output logic [RA_W-1:0]  ie_rd,
   output logic             ie_alu_src,
   output logic [3:0]       ie_alu_op,
   output logic             ie_mem_read,
   output logic             ie_mem_write,
   output logic             ie_reg_write,
   output logic             hazard_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   logic rs1_hit;
   logic rs2_hit;
   logic lu;

   // A load in IE whose rd (never x0) feeds the instruction now in ID must wait one cycle.
   assign rs1_hit      = id_uses_rs1 && (id_rs1 == ie_rd);
   assign rs2_hit      = id_uses_rs2 && (id_rs2 == ie_rd);
   assign lu           = ie_valid && ie_mem_read && (ie_rd != '0) && id_valid && (rs1_hit || rs2_hit);
   assign hazard_stall = lu && !flush && !stall_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie_valid     <= 1'b0;
         ie_pc        <= '0;
         ie_rs1_data  <= '0;
         ie_rs2_data  <= '0;
         ie_imm       <= '0;
         ie_rs1       <= '0;
         ie_rs2       <= '0;
         ie_rd        <= '0;
         ie_alu_src   <= 1'b0;
         ie_alu_op    <= '0;
         ie_mem_read  <= 1'b0;
         ie_mem_write <= 1'b0;
         ie_reg_write <= 1'b0;
         bubble_cnt   <= '0;
      end else if (flush || !stall_ext) begin
         // Flush and load-use both leave an all-zero slot; only load-use is counted.
         if (flush || lu) begin
            ie_valid     <= 1'b0;
            ie_pc        <= '0;
            ie_rs1_data  <= '0;
            ie_rs2_data  <= '0;
            ie_imm       <= '0;
            ie_rs1       <= '0;
            ie_rs2       <= '0;
            ie_rd        <= '0;
            ie_alu_src   <= 1'b0;
            ie_alu_op    <= '0;
            ie_mem_read  <= 1'b0;
            ie_mem_write <= 1'b0;
            ie_reg_write <= 1'b0;
         end else begin
            ie_valid     <= id_valid;
            ie_pc        <= id_pc;
            ie_rs1_data  <= id_rs1_data;
            ie_rs2_data  <= id_rs2_data;
            ie_imm       <= id_imm;
            ie_rs1       <= id_rs1;
            ie_rs2       <= id_rs2;
            ie_rd        <= id_rd;
            ie_alu_src   <= id_alu_src;
            ie_alu_op    <= id_alu_op;
            ie_mem_read  <= id_valid && id_mem_read;
            ie_mem_write <= id_valid && id_mem_write;
            ie_reg_write <= id_valid && id_reg_write;
         end
         if (!flush && lu && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ie_pipe_reg.sv
// Scoreboard bench for id_ie_pipe_reg: expected IE slots and counter values are queued
// when ID stimulus is driven and compared one clock later.
module tb_id_ie_pipe_reg;

   localparam int XLEN  = 32;
   localparam int RA_W  = 5;
   localparam int CNT_W = 16;
   localparam int SAT_W = 4;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [RA_W-1:0] rd;
      logic            uses_rs1;
      logic            uses_rs2;
      logic            alu_src;
      logic [3:0]      alu_op;
      logic            mem_read;
      logic            mem_write;
      logic            reg_write;
   } instr_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [RA_W-1:0] rd;
      logic            alu_src;
      logic [3:0]      alu_op;
      logic            mem_read;
      logic            mem_write;
      logic            reg_write;
   } slot_t;

   localparam slot_t ZERO = '0;

   logic             clk;
   logic             rst_n;
   logic             rst_n_sat;
   logic             id_valid;
   logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [RA_W-1:0]  id_rs1, id_rs2, id_rd;
   logic             id_uses_rs1, id_uses_rs2, id_alu_src;
   logic [3:0]       id_alu_op;
   logic             id_mem_read, id_mem_write, id_reg_write;
   logic             flush, stall_ext;

   logic             ie_valid;
   logic [XLEN-1:0]  ie_pc, ie_rs1_data, ie_rs2_data, ie_imm;
   logic [RA_W-1:0]  ie_rs1, ie_rs2, ie_rd;
   logic             ie_alu_src;
   logic [3:0]       ie_alu_op;
   logic             ie_mem_read, ie_mem_write, ie_reg_write;
   logic             hazard_stall;
   logic [CNT_W-1:0] bubble_cnt;

   logic             s_ie_valid;
   logic [XLEN-1:0]  s_ie_pc, s_ie_rs1_data, s_ie_rs2_data, s_ie_imm;
   logic [RA_W-1:0]  s_ie_rs1, s_ie_rs2, s_ie_rd;
   logic             s_ie_alu_src;
   logic [3:0]       s_ie_alu_op;
   logic             s_ie_mem_read, s_ie_mem_write, s_ie_reg_write;
   logic             s_hazard_stall;
   logic [SAT_W-1:0] s_bubble_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   slot_t            exp_slot_q[$];
   logic [CNT_W-1:0] exp_cnt_q[$];
   logic [SAT_W-1:0] sat_q[$];
   logic [CNT_W-1:0] exp_cnt;

   instr_t lw5, add5, lw0, add0, cap_a, inval;

   id_ie_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_alu_src(id_alu_src),
      .id_alu_op(id_alu_op), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_reg_write(id_reg_write), .flush(flush), .stall_ext(stall_ext),
      .ie_valid(ie_valid), .ie_pc(ie_pc), .ie_rs1_data(ie_rs1_data), .ie_rs2_data(ie_rs2_data),
      .ie_imm(ie_imm), .ie_rs1(ie_rs1), .ie_rs2(ie_rs2), .ie_rd(ie_rd),
      .ie_alu_src(ie_alu_src), .ie_alu_op(ie_alu_op), .ie_mem_read(ie_mem_read),
      .ie_mem_write(ie_mem_write), .ie_reg_write(ie_reg_write),
      .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   id_ie_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(SAT_W)) dut_sat (
      .clk(clk), .rst_n(rst_n_sat),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_alu_src(id_alu_src),
      .id_alu_op(id_alu_op), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_reg_write(id_reg_write), .flush(flush), .stall_ext(stall_ext),
      .ie_valid(s_ie_valid), .ie_pc(s_ie_pc), .ie_rs1_data(s_ie_rs1_data), .ie_rs2_data(s_ie_rs2_data),
      .ie_imm(s_ie_imm), .ie_rs1(s_ie_rs1), .ie_rs2(s_ie_rs2), .ie_rd(s_ie_rd),
      .ie_alu_src(s_ie_alu_src), .ie_alu_op(s_ie_alu_op), .ie_mem_read(s_ie_mem_read),
      .ie_mem_write(s_ie_mem_write), .ie_reg_write(s_ie_reg_write),
      .hazard_stall(s_hazard_stall), .bubble_cnt(s_bubble_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time expired, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   function automatic slot_t expect_capture(input instr_t i);
      slot_t s;
      s.valid     = i.valid;
      s.pc        = i.pc;
      s.rs1_data  = i.rs1_data;
      s.rs2_data  = i.rs2_data;
      s.imm       = i.imm;
      s.rs1       = i.rs1;
      s.rs2       = i.rs2;
      s.rd        = i.rd;
      s.alu_src   = i.alu_src;
      s.alu_op    = i.alu_op;
      s.mem_read  = i.valid & i.mem_read;
      s.mem_write = i.valid & i.mem_write;
      s.reg_write = i.valid & i.reg_write;
      return s;
   endfunction

   function automatic slot_t observe();
      return {ie_valid, ie_pc, ie_rs1_data, ie_rs2_data, ie_imm, ie_rs1, ie_rs2, ie_rd,
              ie_alu_src, ie_alu_op, ie_mem_read, ie_mem_write, ie_reg_write};
   endfunction

   function automatic slot_t observe_sat();
      return {s_ie_valid, s_ie_pc, s_ie_rs1_data, s_ie_rs2_data, s_ie_imm, s_ie_rs1, s_ie_rs2, s_ie_rd,
              s_ie_alu_src, s_ie_alu_op, s_ie_mem_read, s_ie_mem_write, s_ie_reg_write};
   endfunction

   function automatic instr_t rand_instr();
      instr_t r;
      r.valid     = 1'($urandom_range(1, 0));
      r.pc        = $urandom();
      r.rs1_data  = $urandom();
      r.rs2_data  = $urandom();
      r.imm       = $urandom();
      r.rs1       = 5'($urandom_range(31, 0));
      r.rs2       = 5'($urandom_range(31, 0));
      r.rd        = 5'($urandom_range(31, 0));
      r.uses_rs1  = 1'($urandom_range(1, 0));
      r.uses_rs2  = 1'($urandom_range(1, 0));
      r.alu_src   = 1'($urandom_range(1, 0));
      r.alu_op    = 4'($urandom_range(15, 0));
      r.mem_read  = 1'b0;
      r.mem_write = 1'($urandom_range(1, 0));
      r.reg_write = 1'($urandom_range(1, 0));
      return r;
   endfunction

   task automatic init_instrs();
      lw5 = '0;
      lw5.valid = 1'b1;  lw5.pc = 32'h200;  lw5.rs1_data = 32'h1000;  lw5.imm = 32'h8;
      lw5.rs1 = 5'd2;    lw5.rd = 5'd5;     lw5.uses_rs1 = 1'b1;
      lw5.alu_src = 1'b1; lw5.mem_read = 1'b1; lw5.reg_write = 1'b1;
      add5 = '0;
      add5.valid = 1'b1; add5.pc = 32'h204;  add5.rs1_data = 32'h11; add5.rs2_data = 32'h22;
      add5.rs1 = 5'd6;   add5.rs2 = 5'd5;    add5.rd = 5'd7;
      add5.uses_rs1 = 1'b1; add5.uses_rs2 = 1'b1; add5.reg_write = 1'b1;
      lw0 = lw5;
      lw0.pc = 32'h208;  lw0.rd = 5'd0;
      add0 = add5;
      add0.pc = 32'h20C; add0.rs1 = 5'd0;    add0.rs2 = 5'd0;
      cap_a = '0;
      cap_a.valid = 1'b1; cap_a.pc = 32'h100; cap_a.imm = 32'hFFFF_FFF0;
      cap_a.rs1_data = 32'hA5A5; cap_a.rs2_data = 32'h5A5A;
      cap_a.rs1 = 5'd1;  cap_a.rs2 = 5'd2;   cap_a.rd = 5'd3;
      cap_a.alu_src = 1'b1; cap_a.alu_op = 4'h2; cap_a.reg_write = 1'b1;
      inval = '0;
      inval.valid = 1'b0; inval.pc = 32'h300; inval.imm = 32'h44; inval.rd = 5'd9;
      inval.alu_src = 1'b1; inval.alu_op = 4'h7;
      inval.mem_read = 1'b1; inval.mem_write = 1'b1; inval.reg_write = 1'b1;
   endtask

   task automatic drive(input instr_t i, input logic f, input logic s);
      id_valid     = i.valid;
      id_pc        = i.pc;
      id_rs1_data  = i.rs1_data;
      id_rs2_data  = i.rs2_data;
      id_imm       = i.imm;
      id_rs1       = i.rs1;
      id_rs2       = i.rs2;
      id_rd        = i.rd;
      id_uses_rs1  = i.uses_rs1;
      id_uses_rs2  = i.uses_rs2;
      id_alu_src   = i.alu_src;
      id_alu_op    = i.alu_op;
      id_mem_read  = i.mem_read;
      id_mem_write = i.mem_write;
      id_reg_write = i.reg_write;
      flush        = f;
      stall_ext    = s;
   endtask

   task automatic push(input slot_t s);
      exp_slot_q.push_back(s);
      exp_cnt_q.push_back(exp_cnt);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      total_cnt++;
      if (observe() !== ZERO) $display("[TB] FAIL reset_slot: got %h expected %h", observe(), ZERO);
      else pass_cnt++;
      total_cnt++;
      if (bubble_cnt !== '0) $display("[TB] FAIL reset_cnt: got %h expected 0", bubble_cnt);
      else pass_cnt++;
      total_cnt++;
      if (hazard_stall !== 1'b0) $display("[TB] FAIL reset_hz: got %b expected 0", hazard_stall);
      else pass_cnt++;
      exp_cnt = '0;
      rst_n   = 1'b1;
   endtask

   task automatic test_capture();
      instr_t ids[2];
      slot_t  got, want;
      logic [CNT_W-1:0] wcnt;
      ids = '{cap_a, inval};
      for (int k = 0; k < 2; k++) begin
         drive(ids[k], 1'b0, 1'b0);
         push(expect_capture(ids[k]));
         tick();
         got = observe(); want = exp_slot_q.pop_front(); wcnt = exp_cnt_q.pop_front();
         total_cnt++;
         if (got !== want) $display("[TB] FAIL capture_slot[%0d]: got %h expected %h", k, got, want);
         else pass_cnt++;
         total_cnt++;
         if (bubble_cnt !== wcnt) $display("[TB] FAIL capture_cnt[%0d]: got %h expected %h", k, bubble_cnt, wcnt);
         else pass_cnt++;
      end
   endtask

   task automatic test_load_use();
      instr_t ids[5];
      logic   hz[5];
      slot_t  exp[5];
      int     inc[5];
      slot_t  got, want;
      logic [CNT_W-1:0] wcnt;
      ids = '{lw5, add5, add5, lw0, add0};
      hz  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      exp = '{expect_capture(lw5), ZERO, expect_capture(add5), expect_capture(lw0), expect_capture(add0)};
      inc = '{0, 1, 0, 0, 0};
      for (int k = 0; k < 5; k++) begin
         drive(ids[k], 1'b0, 1'b0);
         #1;
         total_cnt++;
         if (hazard_stall !== hz[k]) $display("[TB] FAIL load_use_hz[%0d]: got %b expected %b", k, hazard_stall, hz[k]);
         else pass_cnt++;
         exp_cnt += CNT_W'(inc[k]);
         push(exp[k]);
         tick();
         got = observe(); want = exp_slot_q.pop_front(); wcnt = exp_cnt_q.pop_front();
         total_cnt++;
         if (got !== want) $display("[TB] FAIL load_use_slot[%0d]: got %h expected %h", k, got, want);
         else pass_cnt++;
         total_cnt++;
         if (bubble_cnt !== wcnt) $display("[TB] FAIL load_use_cnt[%0d]: got %h expected %h", k, bubble_cnt, wcnt);
         else pass_cnt++;
      end
   endtask

   task automatic test_flush_vs_lu();
      instr_t ids[4];
      logic   fl[4];
      slot_t  exp[4];
      slot_t  got, want;
      logic [CNT_W-1:0] wcnt;
      ids = '{lw5, add5, add5, lw5};
      fl  = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp = '{expect_capture(lw5), ZERO, expect_capture(add5), ZERO};
      for (int k = 0; k < 4; k++) begin
         drive(ids[k], fl[k], 1'b0);
         #1;
         total_cnt++;
         if (hazard_stall !== 1'b0) $display("[TB] FAIL flush_hz[%0d]: got %b expected 0", k, hazard_stall);
         else pass_cnt++;
         push(exp[k]);
         tick();
         got = observe(); want = exp_slot_q.pop_front(); wcnt = exp_cnt_q.pop_front();
         total_cnt++;
         if (got !== want) $display("[TB] FAIL flush_slot[%0d]: got %h expected %h", k, got, want);
         else pass_cnt++;
         total_cnt++;
         if (bubble_cnt !== wcnt) $display("[TB] FAIL flush_cnt[%0d]: got %h expected %h", k, bubble_cnt, wcnt);
         else pass_cnt++;
      end
   endtask

   task automatic test_stall_ext();
      instr_t ids[9];
      logic   st[9];
      logic   hz[9];
      slot_t  exp[9];
      int     inc[9];
      slot_t  got, want;
      logic [CNT_W-1:0] wcnt;
      instr_t r4;
      r4  = rand_instr();
      ids = '{lw5, add5, add5, add5, cap_a, rand_instr(), rand_instr(), rand_instr(), r4};
      st  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      hz  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      exp = '{expect_capture(lw5), expect_capture(lw5), ZERO, expect_capture(add5),
              expect_capture(cap_a), expect_capture(cap_a), expect_capture(cap_a),
              expect_capture(cap_a), expect_capture(r4)};
      inc = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
      for (int k = 0; k < 9; k++) begin
         drive(ids[k], 1'b0, st[k]);
         #1;
         total_cnt++;
         if (hazard_stall !== hz[k]) $display("[TB] FAIL stall_hz[%0d]: got %b expected %b", k, hazard_stall, hz[k]);
         else pass_cnt++;
         exp_cnt += CNT_W'(inc[k]);
         push(exp[k]);
         tick();
         got = observe(); want = exp_slot_q.pop_front(); wcnt = exp_cnt_q.pop_front();
         total_cnt++;
         if (got !== want) $display("[TB] FAIL stall_slot[%0d]: got %h expected %h", k, got, want);
         else pass_cnt++;
         total_cnt++;
         if (bubble_cnt !== wcnt) $display("[TB] FAIL stall_cnt[%0d]: got %h expected %h", k, bubble_cnt, wcnt);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      instr_t i;
      slot_t  got, want;
      logic [CNT_W-1:0] wcnt;
      for (int k = 0; k < 8; k++) begin
         i = rand_instr();
         drive(i, 1'b0, 1'b0);
         push(expect_capture(i));
         tick();
         got = observe(); want = exp_slot_q.pop_front(); wcnt = exp_cnt_q.pop_front();
         total_cnt++;
         if (got !== want) $display("[TB] FAIL b2b_slot[%0d]: got %h expected %h", k, got, want);
         else pass_cnt++;
         total_cnt++;
         if (bubble_cnt !== wcnt) $display("[TB] FAIL b2b_cnt[%0d]: got %h expected %h", k, bubble_cnt, wcnt);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      slot_t got, want;
      logic [CNT_W-1:0] wcnt;
      drive(lw5, 1'b0, 1'b0);
      push(expect_capture(lw5));
      tick();
      got = observe(); want = exp_slot_q.pop_front(); wcnt = exp_cnt_q.pop_front();
      total_cnt++;
      if (got !== want) $display("[TB] FAIL rstmid_pre_slot: got %h expected %h", got, want);
      else pass_cnt++;
      drive(add5, 1'b0, 1'b0);
      #1;
      total_cnt++;
      if (hazard_stall !== 1'b1) $display("[TB] FAIL rstmid_pre_hz: got %b expected 1", hazard_stall);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      exp_cnt = '0;
      total_cnt++;
      if (observe() !== ZERO) $display("[TB] FAIL rstmid_slot: got %h expected %h", observe(), ZERO);
      else pass_cnt++;
      total_cnt++;
      if (bubble_cnt !== exp_cnt) $display("[TB] FAIL rstmid_cnt: got %h expected %h (pre-reset %h)", bubble_cnt, exp_cnt, wcnt);
      else pass_cnt++;
      total_cnt++;
      if (hazard_stall !== 1'b0) $display("[TB] FAIL rstmid_hz: got %b expected 0", hazard_stall);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (observe() !== ZERO) $display("[TB] FAIL rstmid_held_slot: got %h expected %h", observe(), ZERO);
      else pass_cnt++;
      #1;
      rst_n = 1'b1;
      drive(add5, 1'b0, 1'b0);
      #1;
      total_cnt++;
      if (hazard_stall !== 1'b0) $display("[TB] FAIL rstmid_post_hz: got %b expected 0", hazard_stall);
      else pass_cnt++;
      push(expect_capture(add5));
      tick();
      got = observe(); want = exp_slot_q.pop_front(); wcnt = exp_cnt_q.pop_front();
      total_cnt++;
      if (got !== want) $display("[TB] FAIL rstmid_post_slot: got %h expected %h", got, want);
      else pass_cnt++;
      total_cnt++;
      if (bubble_cnt !== wcnt) $display("[TB] FAIL rstmid_post_cnt: got %h expected %h", bubble_cnt, wcnt);
      else pass_cnt++;
   endtask

   task automatic test_saturation();
      logic [SAT_W-1:0] sat_exp;
      logic [SAT_W-1:0] wsat;
      logic [CNT_W-1:0] wcnt;
      slot_t want;
      sat_exp   = '0;
      rst_n_sat = 1'b1;
      for (int e = 0; e < 17; e++) begin
         drive(lw5, 1'b0, 1'b0);
         push(expect_capture(lw5));
         tick();
         want = exp_slot_q.pop_front(); wcnt = exp_cnt_q.pop_front();
         total_cnt++;
         if (observe_sat() !== want) $display("[TB] FAIL sat_load_slot[%0d]: got %h expected %h", e, observe_sat(), want);
         else pass_cnt++;
         drive(add5, 1'b0, 1'b0);
         #1;
         total_cnt++;
         if (s_hazard_stall !== 1'b1 || hazard_stall !== 1'b1)
            $display("[TB] FAIL sat_hz[%0d]: got %b/%b expected 1/1", e, hazard_stall, s_hazard_stall);
         else pass_cnt++;
         exp_cnt += 1'b1;
         sat_exp = (sat_exp == '1) ? sat_exp : sat_exp + 1'b1;
         sat_q.push_back(sat_exp);
         push(ZERO);
         tick();
         want = exp_slot_q.pop_front(); wcnt = exp_cnt_q.pop_front(); wsat = sat_q.pop_front();
         total_cnt++;
         if (s_bubble_cnt !== wsat) $display("[TB] FAIL sat_cnt[%0d]: got %h expected %h", e, s_bubble_cnt, wsat);
         else pass_cnt++;
         total_cnt++;
         if (bubble_cnt !== wcnt) $display("[TB] FAIL sat_main_cnt[%0d]: got %h expected %h", e, bubble_cnt, wcnt);
         else pass_cnt++;
         total_cnt++;
         if (observe_sat() !== want) $display("[TB] FAIL sat_bubble_slot[%0d]: got %h expected %h", e, observe_sat(), want);
         else pass_cnt++;
      end
   endtask

   initial begin
      clk       = 1'b0;
      rst_n     = 1'b0;
      rst_n_sat = 1'b0;
      exp_cnt   = '0;
      init_instrs();
      drive('0, 1'b0, 1'b0);
      test_reset();
      test_capture();
      test_load_use();
      test_flush_vs_lu();
      test_stall_ext();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/id_ie_pipe_reg.md
Name: id_ie_pipe_reg

Overview:
- ID/IE pipeline boundary register for the 5-stage RISC-V core.
- Captures decoded operands and control from ID, including the ALU operand-B select that the IE-stage 2:1 operand mux consumes (0 = rs2 data, 1 = immediate).
- Inserts bubbles on load-use hazards, squashes the slot on branch flush, and holds on downstream stall.
- Drives the hold request back to IF/ID and keeps a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- RA_W, 5, register-address width.
- CNT_W, 16, bubble-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID slot holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data  in  XLEN  register-file read data, port 1.
- id_rs2_data  in  XLEN  register-file read data, port 2.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1  in  RA_W  source register 1 address.
- id_rs2  in  RA_W  source register 2 address.
- id_rd  in  RA_W  destination register address.
- id_uses_rs1  in  1  instruction reads rs1.
- id_uses_rs2  in  1  instruction reads rs2.
- id_alu_src  in  1  operand-B select for the IE mux.
- id_alu_op  in  4  ALU operation code.
- id_mem_read  in  1  instruction is a load.
- id_mem_write  in  1  instruction is a store.
- id_reg_write  in  1  instruction writes rd.
- flush  in  1  branch/jump taken in IE; squash the ID slot.
- stall_ext  in  1  MEM-side stall; freeze this register.
- ie_valid  out  1  IE slot holds a real instruction.
- ie_pc, ie_rs1_data, ie_rs2_data, ie_imm  out  XLEN each  registered copies.
- ie_rs1, ie_rs2, ie_rd  out  RA_W each  registered copies.
- ie_alu_src  out  1  registered copy.
- ie_alu_op  out  4  registered copy.
- ie_mem_read, ie_mem_write, ie_reg_write  out  1 each  registered copies.
- hazard_stall  out  1  combinational; hold PC and the IF/ID register this cycle.
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output and bubble_cnt go to 0; hazard_stall reads 0 while in reset. Reset asserted mid-operation discards the in-flight slot with no partial update.
- Load-use detect (combinational): lu = ie_valid & ie_mem_read & (ie_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ie_rd) | (id_uses_rs2 & id_rs2==ie_rd)).
- hazard_stall = lu & ~flush & ~stall_ext.
- Per rising edge, priority flush > stall_ext > lu > capture:
  - flush: ie_valid, ie_mem_read, ie_mem_write, ie_reg_write <= 0; all other fields <= 0; no bubble counted.
  - stall_ext (no flush): all ie_* outputs hold; bubble_cnt holds.
  - lu: bubble slot. ie_valid and the three memory/writeback controls <= 0; data fields <= 0; bubble_cnt += 1, saturating at all-ones. The ID instruction stays in ID (hazard_stall=1) and is captured next cycle, when lu is false because the IE slot is now a bubble. Exactly one bubble per load-use.
  - capture: all fields <= id_*; ie_valid <= id_valid. If id_valid=0, the three memory/writeback controls <= 0 regardless of inputs.
- Latency: one cycle from ID to IE outputs; none from inputs to hazard_stall.
- Register x0: a load with rd=0 never triggers lu.
- A flush coincident with lu squashes; hazard_stall=0 and no count.
- A stall_ext coincident with lu: no bubble and no count; lu is re-evaluated when the stall releases.
- ie_alu_src is passed through unmodified; it is 0 in any bubble or flushed slot.

Test Plan:
1. Reset: rst_n=0 mid-stream with ie_valid=1 -> all outputs 0 immediately, before the next clock edge; bubble_cnt=0.
2. Capture: id_valid=1, id_pc=0x100, id_imm=0xFFFFFFF0, id_alu_src=1, id_alu_op=4'h2, id_reg_write=1 -> next cycle ie_pc=0x100, ie_imm=0xFFFFFFF0, ie_alu_src=1, ie_alu_op=4'h2, ie_reg_write=1, ie_valid=1.
3. Load-use: IE holds lw x5 (ie_mem_read=1, ie_rd=5); ID holds add with id_rs2=5, id_uses_rs2=1 -> hazard_stall=1 for one cycle; next IE slot ie_valid=0, ie_reg_write=0; bubble_cnt=1; following cycle the add is captured with ie_valid=1. Repeat with ie_rd=0 -> no stall, bubble_cnt unchanged.
4. Flush vs lu: load-use condition plus flush=1 in the same cycle -> hazard_stall=0, ie_valid=0, bubble_cnt unchanged.
5. stall_ext: hold stall_ext=1 for 3 cycles with changing id_* inputs -> all ie_* outputs constant; on release, the current id_* values are captured.
6. Saturation: preload with 0xFFFF load-use events (CNT_W=16), then one more -> bubble_cnt stays 0xFFFF.
